// File: rtl/if_id_buf_pkg.sv
// Shared constants and entry type for the fetch-to-decode buffer.
// Bus widths and control encodings match the pipeline's common definitions.
package if_id_buf_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0;
  localparam logic [INST_W-1:0]      NOP_INST  = 32'h0;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic DO_FLUSH     = 1'b1;
  localparam logic NO_FLUSH     = 1'b0;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } entry_t;

endpackage

// File: rtl/if_id_buf.sv
// IF/ID boundary queue: captures fetched (pc, inst) pairs in order and presents
// the oldest to decode; back-pressures fetch when full, empties on flush/reset.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [INST_ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0]      if_inst,
  output logic                   if_ready,
  input  logic                   id_stall,
  input  logic                   flush,
  output logic                   id_valid,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic [PTR_W:0]         occupancy
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             enq;
  logic             deq;
  entry_t           head;

  // Both handshakes decode from registered count only, so no input reaches if_ready.
  assign if_ready  = (count != FULL_CNT);
  assign id_valid  = (count != '0);
  assign occupancy = count;

  assign enq = if_valid && if_ready && (flush != DO_FLUSH);
  assign deq = id_valid && (id_stall != STOP) && (flush != DO_FLUSH);

  assign head    = mem[rd_ptr];
  assign id_pc   = id_valid ? head.pc   : ZERO_WORD;
  assign id_inst = id_valid ? head.inst : NOP_INST;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush == DO_FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not cleared; an empty queue masks it at the outputs.
  always_ff @(posedge clk) begin
    if ((rst != RST_ENABLE) && enq) begin
      mem[wr_ptr] <= '{pc: if_pc, inst: if_inst};
    end
  end

endmodule
